// File: rtl/lane_cache_bank.sv
// Multi-lane scratchpad: per-lane write enables, credit-controlled read pipeline into an output queue.
// Optional same-cycle write-to-read forwarding when LANE_CACHE_FWD_EN is defined.
module lane_cache_bank #(
  parameter int LANES      = 4,
  parameter int DWIDTH     = 32,
  parameter int AWIDTH     = 8,
  parameter int LPID_W     = 1,
  parameter int RD_LAT     = 2,
  parameter int OUTQ_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [AWIDTH-1:0]                 i_wrreq_addr,
  input  logic [LANES*DWIDTH-1:0]           i_wrreq_data,
  input  logic [LANES-1:0]                  i_wrreq_be,
  input  logic                              i_wrreq_valid,
  input  logic [AWIDTH-1:0]                 i_rdreq_addr,
  input  logic [LPID_W-1:0]                 i_rdreq_lp_id,
  input  logic                              i_rdreq_valid,
  output logic                              o_rdreq_ready,
  output logic [LANES*DWIDTH-1:0]           o_rdresp_data,
  output logic [LPID_W-1:0]                 o_rdresp_lp_id,
  output logic                              o_rdresp_valid,
  input  logic                              i_rdresp_ready,
  output logic [$clog2(OUTQ_DEPTH+1)-1:0]   o_outstanding
);

  localparam int LW    = LANES * DWIDTH;
  localparam int DEPTH = 2 ** AWIDTH;
  localparam int CW    = $clog2(OUTQ_DEPTH + 1);
  localparam int PW    = $clog2(OUTQ_DEPTH);

  if (OUTQ_DEPTH < RD_LAT + 1) begin : g_depth_chk
    $error("lane_cache_bank: OUTQ_DEPTH must be at least RD_LAT+1");
  end

  logic [LANES-1:0][DWIDTH-1:0] mem_q [DEPTH];

  logic [CW-1:0]     credits_q, credits_d;
  logic [RD_LAT-1:0] pv_q;
  logic [LPID_W-1:0] ptag_q  [RD_LAT];
  logic [LW-1:0]     pdata_q [RD_LAT];
`ifdef LANE_CACHE_FWD_EN
  logic [RD_LAT-1:0] pfwd_q;
  logic [LW-1:0]     pwdata_q [RD_LAT];
  logic [LANES-1:0]  pbe_q    [RD_LAT];
`endif

  logic [LW-1:0]     qdata_q [OUTQ_DEPTH];
  logic [LPID_W-1:0] qtag_q  [OUTQ_DEPTH];
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     qcnt_q;
  logic [LW-1:0]     last_data_q;
  logic [LPID_W-1:0] last_tag_q;

  logic          rd_acc, push, pop, q_nempty;
  logic [LW-1:0] exit_data;

  assign o_rdreq_ready = (credits_q < CW'(OUTQ_DEPTH));
  assign rd_acc        = i_rdreq_valid & o_rdreq_ready;
  assign q_nempty      = (qcnt_q != '0);
  assign pop           = q_nempty & i_rdresp_ready;
  assign push          = pv_q[RD_LAT-1];

  always_comb begin
    credits_d = credits_q;
    case ({rd_acc, pop})
      2'b10:   credits_d = credits_q + 1'b1;
      2'b01:   credits_d = credits_q - 1'b1;
      default: credits_d = credits_q;
    endcase
  end

  always_comb begin
    exit_data = pdata_q[RD_LAT-1];
`ifdef LANE_CACHE_FWD_EN
    if (pfwd_q[RD_LAT-1]) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (pbe_q[RD_LAT-1][i])
          exit_data[i*DWIDTH +: DWIDTH] = pwdata_q[RD_LAT-1][i*DWIDTH +: DWIDTH];
      end
    end
`endif
  end

  // RAM and datapath registers carry no reset; validity is tracked by pv_q/qcnt_q.
  always_ff @(posedge clk) begin
    if (i_wrreq_valid) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (i_wrreq_be[i]) mem_q[i_wrreq_addr][i] <= i_wrreq_data[i*DWIDTH +: DWIDTH];
      end
    end
    pdata_q[0] <= mem_q[i_rdreq_addr];
    ptag_q[0]  <= i_rdreq_lp_id;
`ifdef LANE_CACHE_FWD_EN
    pfwd_q[0]   <= i_wrreq_valid && (i_wrreq_addr == i_rdreq_addr);
    pwdata_q[0] <= i_wrreq_data;
    pbe_q[0]    <= i_wrreq_be;
`endif
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      pdata_q[i] <= pdata_q[i-1];
      ptag_q[i]  <= ptag_q[i-1];
`ifdef LANE_CACHE_FWD_EN
      pfwd_q[i]   <= pfwd_q[i-1];
      pwdata_q[i] <= pwdata_q[i-1];
      pbe_q[i]    <= pbe_q[i-1];
`endif
    end
    if (push) begin
      qdata_q[wptr_q] <= exit_data;
      qtag_q[wptr_q]  <= ptag_q[RD_LAT-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credits_q   <= '0;
      pv_q        <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      qcnt_q      <= '0;
      last_data_q <= '0;
      last_tag_q  <= '0;
    end else begin
      credits_q <= credits_d;
      pv_q[0]   <= rd_acc;
      for (int unsigned i = 1; i < RD_LAT; i++) pv_q[i] <= pv_q[i-1];
      if (push) wptr_q <= (wptr_q == PW'(OUTQ_DEPTH - 1)) ? '0 : wptr_q + 1'b1;
      if (pop) begin
        rptr_q      <= (rptr_q == PW'(OUTQ_DEPTH - 1)) ? '0 : rptr_q + 1'b1;
        last_data_q <= qdata_q[rptr_q];
        last_tag_q  <= qtag_q[rptr_q];
      end
      if (push && !pop)      qcnt_q <= qcnt_q + 1'b1;
      else if (pop && !push) qcnt_q <= qcnt_q - 1'b1;
    end
  end

  // Idle outputs show the last popped entry so they hold their value while valid=0.
  assign o_rdresp_valid = q_nempty;
  assign o_rdresp_data  = q_nempty ? qdata_q[rptr_q] : last_data_q;
  assign o_rdresp_lp_id = q_nempty ? qtag_q[rptr_q]  : last_tag_q;
  assign o_outstanding  = credits_q;

endmodule

// File: tb/tb_lane_cache_bank.sv
// Scoreboard bench for lane_cache_bank: line-level memory model, response queue, decoupled monitor.
`timescale 1ns/100ps
module tb_lane_cache_bank;
  localparam int LANES = 4, DWIDTH = 32, AWIDTH = 8, LPID_W = 1, RD_LAT = 2, OUTQ_DEPTH = 4;
  localparam int LW = LANES * DWIDTH;
  localparam int CW = $clog2(OUTQ_DEPTH + 1);

  logic              clk, reset;
  logic [AWIDTH-1:0] wr_addr, rd_addr;
  logic [LW-1:0]     wr_data, resp_data;
  logic [LANES-1:0]  wr_be;
  logic              wr_valid, rd_valid, rd_ready, resp_valid, resp_ready;
  logic [LPID_W-1:0] rd_tag, resp_tag;
  logic [CW-1:0]     outstanding;

  lane_cache_bank #(.LANES(LANES), .DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .LPID_W(LPID_W),
                    .RD_LAT(RD_LAT), .OUTQ_DEPTH(OUTQ_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .i_wrreq_addr(wr_addr), .i_wrreq_data(wr_data), .i_wrreq_be(wr_be), .i_wrreq_valid(wr_valid),
    .i_rdreq_addr(rd_addr), .i_rdreq_lp_id(rd_tag), .i_rdreq_valid(rd_valid), .o_rdreq_ready(rd_ready),
    .o_rdresp_data(resp_data), .o_rdresp_lp_id(resp_tag), .o_rdresp_valid(resp_valid),
    .i_rdresp_ready(resp_ready), .o_outstanding(outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [LW-1:0]     data;
    logic [LPID_W-1:0] tag;
  } exp_t;

  exp_t          sbq[$];
  logic [LW-1:0] mdl [0:(2**AWIDTH)-1];
  int            errors = 0, checks = 0, n_acc = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // One cycle of stimulus; the expected response is computed from the model before the same-cycle write.
  task automatic drive(input logic wv, input logic [AWIDTH-1:0] wa, input logic [LW-1:0] wd,
                       input logic [LANES-1:0] be, input logic rv, input logic [AWIDTH-1:0] ra,
                       input logic [LPID_W-1:0] tag, input logic rr);
    exp_t e;
    @(negedge clk);
    wr_valid = wv; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_valid = rv; rd_addr = ra; rd_tag = tag; resp_ready = rr;
    #1;
    if (rv && rd_ready) begin
      e.data = mdl[ra];
`ifdef LANE_CACHE_FWD_EN
      if (wv && wa == ra)
        for (int l = 0; l < LANES; l++)
          if (be[l]) e.data[l*DWIDTH +: DWIDTH] = wd[l*DWIDTH +: DWIDTH];
`endif
      e.tag = tag;
      sbq.push_back(e);
      n_acc++;
    end
    if (wv)
      for (int l = 0; l < LANES; l++)
        if (be[l]) mdl[wa][l*DWIDTH +: DWIDTH] = wd[l*DWIDTH +: DWIDTH];
  endtask

  task automatic idle(input logic rr);
    drive(1'b0, '0, '0, '0, 1'b0, '0, '0, rr);
  endtask

  task automatic drain();
    int k = 0;
    while (sbq.size() != 0 && k < 100) begin
      idle(1'b1); #3; k++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d responses missing, required 0", sbq.size());
    end
    repeat (3) idle(1'b1);
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stability under backpressure.
  logic hold_v = 1'b0;
  exp_t hold_e, mon_e;
  always @(negedge clk) begin
    #3;
    if (reset) hold_v = 1'b0;
    else begin
      if (hold_v) begin
        checks++;
        if (!resp_valid || resp_data !== hold_e.data || resp_tag !== hold_e.tag) begin
          errors++;
          $display("FAIL stall_hold: got valid=%0b data=%0h tag=%0h required valid=1 data=%0h tag=%0h",
                   resp_valid, resp_data, resp_tag, hold_e.data, hold_e.tag);
        end
      end
      if (resp_valid && resp_ready) begin
        hold_v = 1'b0;
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: got data=%0h tag=%0h required no response", resp_data, resp_tag);
        end else begin
          mon_e = sbq.pop_front();
          chk("resp_data", resp_data, mon_e.data);
          chk("resp_tag", LW'(resp_tag), LW'(mon_e.tag));
        end
      end else if (resp_valid) begin
        hold_v = 1'b1;
        hold_e.data = resp_data;
        hold_e.tag  = resp_tag;
      end else hold_v = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [LW-1:0] wd;
    reset = 1'b1;
    wr_valid = 0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rd_valid = 0; rd_addr = '0; rd_tag = '0; resp_ready = 0;
    repeat (2) @(negedge clk);
    #4;
    chk("rst_ready", LW'(rd_ready), LW'(1));
    chk("rst_valid", LW'(resp_valid), '0);
    chk("rst_outstanding", LW'(outstanding), '0);
    chk("rst_data", resp_data, '0);
    chk("rst_tag", LW'(resp_tag), '0);
    @(negedge clk) reset = 1'b0;

    // Full-line write then read with latency check
    drive(1'b1, 8'd5, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 4'b1111,
          1'b0, '0, '0, 1'b1);
    drive(1'b0, '0, '0, '0, 1'b1, 8'd5, 1'b1, 1'b1);
    for (int k = 1; k <= RD_LAT + 1; k++) begin
      idle(1'b1); #3;
      chk("lat_valid", LW'(resp_valid), (k == RD_LAT + 1) ? LW'(1) : LW'(0));
    end
    drain();

    // Partial-lane write over an all-ones line
    drive(1'b1, 8'd7, {4{32'hFFFFFFFF}}, 4'b1111, 1'b0, '0, '0, 1'b1);
    drive(1'b1, 8'd7, {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0}, 4'b0101,
          1'b0, '0, '0, 1'b1);
    drive(1'b0, '0, '0, '0, 1'b1, 8'd7, 1'b0, 1'b1);
    drain();

    // Consumer stall: credits saturate at OUTQ_DEPTH
    n_acc = 0;
    for (int i = 0; i < 10; i++)
      drive(1'b0, '0, '0, '0, 1'b1, (i % 2 == 0) ? 8'd5 : 8'd7, LPID_W'(i), 1'b0);
    #3;
    chk("stall_accepts", LW'(n_acc), LW'(OUTQ_DEPTH));
    chk("stall_ready", LW'(rd_ready), '0);
    chk("stall_outstanding", LW'(outstanding), LW'(OUTQ_DEPTH));
    idle(1'b1); #3;
    chk("ready_before_pop", LW'(rd_ready), '0);
    idle(1'b1); #3;
    chk("ready_after_pop", LW'(rd_ready), LW'(1));
    drain();

    // Same-cycle read and write to one address
    drive(1'b1, 8'd3, {4{32'h0000000A}}, 4'b1111, 1'b0, '0, '0, 1'b1);
    drive(1'b1, 8'd3, {4{32'h0000000B}}, 4'b1111, 1'b1, 8'd3, 1'b1, 1'b1);
    drain();

    // Reset with reads in flight
    for (int i = 0; i < 3; i++) drive(1'b0, '0, '0, '0, 1'b1, 8'd5, 1'b1, 1'b0);
    @(negedge clk);
    rd_valid = 1'b0; resp_ready = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", LW'(resp_valid), '0);
    chk("mid_rst_outstanding", LW'(outstanding), '0);
    chk("mid_rst_ready", LW'(rd_ready), LW'(1));
    chk("mid_rst_data", resp_data, '0);
    chk("mid_rst_tag", LW'(resp_tag), '0);
    sbq.delete();
    @(negedge clk) reset = 1'b0;
    repeat (8) idle(1'b1);
    #3;
    chk("post_rst_outstanding", LW'(outstanding), '0);

    // Randomized traffic over a small address window to provoke collisions
    for (int a = 0; a < 16; a++) begin
      for (int l = 0; l < LANES; l++) wd[l*DWIDTH +: DWIDTH] = DWIDTH'($urandom);
      drive(1'b1, AWIDTH'(a), wd, '1, 1'b0, '0, '0, 1'b1);
    end
    for (int c = 0; c < 400; c++) begin
      for (int l = 0; l < LANES; l++) wd[l*DWIDTH +: DWIDTH] = DWIDTH'($urandom);
      drive(1'($urandom), AWIDTH'($urandom_range(0, 15)), wd, LANES'($urandom),
            ($urandom_range(0, 3) != 0), AWIDTH'($urandom_range(0, 15)), LPID_W'($urandom),
            1'($urandom));
    end
    drain();
    #3;
    chk("final_outstanding", LW'(outstanding), '0);
    chk("final_valid", LW'(resp_valid), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lane_cache_bank.md
# lane_cache_bank

Parametrised multi-lane scratchpad that replaces the fixed-geometry CPU cache in the LU datapath. It holds LANES independent RAM slices that share one line address. Writes are fire-and-forget with per-lane enables. Reads use a credit-controlled, non-stalling pipeline that drains into an output queue, so a slow consumer throttles `o_rdreq_ready` instead of clock-gating the RAMs.

## Interface
- LANES, 4, number of lanes (power of two, 1..16)
- DWIDTH, 32, bits per lane word
- AWIDTH, 8, line-address bits; depth per lane = 2**AWIDTH
- LPID_W, 1, width of requester tag carried request→response
- RD_LAT, 2, RAM read latency in cycles (1..4)
- OUTQ_DEPTH, 4, output queue entries; elaboration error if OUTQ_DEPTH < RD_LAT+1
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- i_wrreq_addr  in  AWIDTH  write line address
- i_wrreq_data  in  LANES*DWIDTH  lane i at bits [i*DWIDTH +: DWIDTH]
- i_wrreq_be  in  LANES  per-lane write enable
- i_wrreq_valid  in  1  write strobe; always accepted
- i_rdreq_addr  in  AWIDTH  read line address
- i_rdreq_lp_id  in  LPID_W  requester tag
- i_rdreq_valid  in  1  read request valid
- o_rdreq_ready  out  1  read request accepted when valid&ready
- o_rdresp_data  out  LANES*DWIDTH  read data, all lanes
- o_rdresp_lp_id  out  LPID_W  tag of the request
- o_rdresp_valid  out  1  response valid
- i_rdresp_ready  in  1  consumer ready
- o_outstanding  out  $clog2(OUTQ_DEPTH+1)  credits in use

## Operation
- Write: when i_wrreq_valid=1, each lane i with i_wrreq_be[i]=1 stores its word at i_wrreq_addr. Lanes with be=0 keep their old contents. The write commits at the clk edge.
- Read accept: a read is accepted when i_rdreq_valid & o_rdreq_ready. The address and tag enter a RD_LAT-stage valid/tag shift pipeline that never stalls.
- Pipeline exit: at the exit stage, data, tag and valid are pushed into the output queue (FIFO, OUTQ_DEPTH entries). The queue head drives o_rdresp_*.
- Pop: the head is popped on o_rdresp_valid & i_rdresp_ready.
- Credits: the counter increments on accept and decrements on pop. Accept and pop in the same cycle leave it unchanged. It counts in-flight plus queued requests.
- Ready: o_rdreq_ready = (credits < OUTQ_DEPTH), registered-free combinational from the counter only, with no dependency on i_rdreq_valid. Because of the credit limit the queue never overflows, and a push into a full queue is impossible by construction.
- Ordering: responses are strictly in request order, with the tag preserved.
- Data on idle outputs: o_rdresp_data and o_rdresp_lp_id hold their last value while valid=0. After reset they hold 0.
- RAM contents: not reset, and undefined until written.

## Timing
- Read latency: a read accepted at cycle t with the queue empty shows o_rdresp_valid=1 in cycle t+RD_LAT+1.
- Throughput: one read per cycle sustained with i_rdresp_ready=1, provided OUTQ_DEPTH ≥ RD_LAT+2. With OUTQ_DEPTH = RD_LAT+1, throughput drops to RD_LAT+1 accepts per RD_LAT+2 cycles.
- Write visibility: a write at cycle t is visible to any read accepted at cycle t+1 or later.
- Consumer stall: with i_rdresp_ready=0, o_rdreq_ready falls in the cycle the credits reach OUTQ_DEPTH. It rises the cycle after the first pop.
- Reset (asynchronous, applicable mid-operation): credits, pipeline valids and queue pointers go to 0, and in-flight reads are discarded. Output reset values: o_rdreq_ready=1, o_rdresp_valid=0, o_rdresp_data=0, o_rdresp_lp_id=0, o_outstanding=0.
- Backpressure: o_rdresp_* must stay stable while valid=1 and ready=0.

## Configuration
- LANE_CACHE_FWD_EN defined: a read accepted in the same cycle as a write to the same address returns the new word for lanes with be=1 and the old word for the others. The write data and be mask are captured alongside the read in the pipeline and merged at the exit.
- LANE_CACHE_FWD_EN undefined: the same-cycle same-address read returns the old contents of all lanes. No forwarding registers are built.

## Test plan
- Write 0x11111111..0x44444444 to address 5 with be=4'b1111, then read address 5 at t+1 with lp_id=1 → o_rdresp_valid at t+1+RD_LAT+1 with those data and lp_id=1.
- Write address 7 with be=4'b0101 over a line previously all 0xFFFFFFFF → read returns lanes 0,2 new and lanes 1,3 0xFFFFFFFF.
- Hold i_rdresp_ready=0 and issue 10 back-to-back reads → exactly OUTQ_DEPTH accepted, o_rdreq_ready=0, o_outstanding=OUTQ_DEPTH. Then release → all responses arrive in order with no loss or duplicate.
- Issue a same-cycle read and write to address 3 (old 0xA, new 0xB, be all ones) → returns 0xB with LANE_CACHE_FWD_EN and 0xA without it.
- Assert reset with 3 reads in flight → next cycle o_rdresp_valid=0, o_outstanding=0, o_rdreq_ready=1, and no stale response appears afterwards.
- Random reads with i_rdresp_ready toggling 50% → checking each response against a reference model shows ordering, tags and data preserved at full LANES width.
